// File: rtl/screen_sequencer.sv
// Top-level screen FSM (title / play / game over) and overlay/game pixel compositor.
// Optional title blinking is enabled by defining SCREEN_BLINK_EN.
module screen_sequencer #(
  parameter logic [11:0] TEXT_RGB       = 12'hFFF,
  parameter logic [11:0] GAME_RGB       = 12'hFFF,
  parameter logic [11:0] DIM_RGB        = 12'h444,
  parameter logic [11:0] BG_RGB         = 12'h000,
  parameter int unsigned BLINK_FRAMES   = 30,
  parameter int unsigned BLINK_Y_MIN    = 183,
  parameter int unsigned HOLDOFF_FRAMES = 60
) (
  input  logic        clk_0,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        in_text,
  input  logic        in_game,
  input  logic        key_pressed,
  input  logic        game_over,
  output logic [11:0] vga_rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        game_run,
  output logic [1:0]  state
);

  localparam int unsigned HoldW = $clog2(HOLDOFF_FRAMES + 2);

  if (BLINK_FRAMES == 0) begin : g_bad_blink_cfg
    $error("BLINK_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {
    StTitle    = 2'd0,
    StPlay     = 2'd1,
    StGameOver = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [HoldW-1:0]   holdoff_q, holdoff_d;
  logic               game_run_q, game_run_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               hs2_q, vs2_q;
  logic               von1_q, hs1_q, vs1_q;
  logic [9:0]         y1_q;
  logic               blink_on;
  logic               frame_tick;

  assign frame_tick = (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // State register plus the two-stage video delay line.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q    <= StTitle;
      pend_q     <= 1'b0;
      holdoff_q  <= '0;
      game_run_q <= 1'b0;
      rgb_q      <= 12'h000;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
      von1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      y1_q       <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      holdoff_q  <= holdoff_d;
      game_run_q <= game_run_d;
      rgb_q      <= rgb_d;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      von1_q     <= video_on;
      hs1_q      <= hsync;
      vs1_q      <= vsync;
      y1_q       <= pixel_y;
    end
  end

  // Events are latched into pend and only acted on at a frame boundary; an event
  // coinciding with a boundary that has nothing pending waits for the next one.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    holdoff_d = holdoff_q;
    case (state_q)
      StTitle: begin
        if (frame_tick && pend_q) begin
          state_d = StPlay;
          pend_d  = 1'b0;
        end else if (key_pressed) begin
          pend_d = 1'b1;
        end
      end
      StPlay: begin
        if (frame_tick && pend_q) begin
          state_d   = StGameOver;
          holdoff_d = HoldW'(HOLDOFF_FRAMES);
          pend_d    = 1'b0;
        end else if (game_over) begin
          pend_d = 1'b1;
        end
      end
      StGameOver: begin
        if (frame_tick && (holdoff_q != '0)) begin
          holdoff_d = holdoff_q - 1'b1;
        end
        if (frame_tick && pend_q) begin
          state_d = StTitle;
          pend_d  = 1'b0;
        end else if (key_pressed && (holdoff_q == '0)) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = StTitle;
        pend_d  = 1'b0;
      end
    endcase
  end

`ifdef SCREEN_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;

  always_ff @(posedge clk_0) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if ((state_d == StTitle) && (state_q != StTitle)) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if ((state_q == StTitle) && frame_tick) begin
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_on = blink_on_q;
`else
  assign blink_on = 1'b1;
`endif

  // Overlay/game bits arrive one cycle late, so they pair with the stage-1 flags.
  always_comb begin
    game_run_d = (state_d == StPlay);
    rgb_d      = BG_RGB;
    if (!von1_q) begin
      rgb_d = 12'h000;
    end else begin
      case (state_q)
        StTitle: begin
          if (in_text && ((y1_q < 10'(BLINK_Y_MIN)) || blink_on)) rgb_d = TEXT_RGB;
        end
        StPlay: begin
          if (in_game) rgb_d = GAME_RGB;
        end
        StGameOver: begin
          if (in_text) rgb_d = TEXT_RGB;
          else if (in_game) rgb_d = DIM_RGB;
        end
        default: rgb_d = BG_RGB;
      endcase
    end
  end

  assign vga_rgb   = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign game_run  = game_run_q;
  assign state     = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: directed frames, expectations queued by cycle.
module tb_screen_sequencer;

  logic        clk_0 = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic        in_text = 1'b0, in_game = 1'b0;
  logic        key_pressed = 1'b0, game_over = 1'b0;
  logic [11:0] vga_rgb;
  logic        hsync_out, vsync_out, game_run;
  logic [1:0]  state;

  screen_sequencer dut (
    .clk_0       (clk_0),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .hsync       (hsync),
    .vsync       (vsync),
    .in_text     (in_text),
    .in_game     (in_game),
    .key_pressed (key_pressed),
    .game_over   (game_over),
    .vga_rgb     (vga_rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .game_run    (game_run),
    .state       (state)
  );

  always #5 clk_0 = ~clk_0;

  int unsigned cyc = 0;
  always @(posedge clk_0) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int unsigned what;  // 0 rgb, 1 hsync_out, 2 vsync_out, 3 state, 4 game_run
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic txt_prev = 1'b0, gm_prev = 1'b0;

  function automatic logic [11:0] pick(input int unsigned what);
    case (what)
      0:       return vga_rgb;
      1:       return {11'd0, hsync_out};
      2:       return {11'd0, vsync_out};
      3:       return {10'd0, state};
      default: return {11'd0, game_run};
    endcase
  endfunction

  // Monitor: compare every queued expectation that falls due on this cycle.
  always @(negedge clk_0) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        logic [11:0] act;
        act = pick(sb[i].what);
        total++;
        if (sb[i].at < cyc) begin
          bad++;
          $display("FAIL %s: stale check (due %0d, now %0d)", sb[i].name, sb[i].at, cyc);
        end else if (act !== sb[i].val) begin
          bad++;
          $display("FAIL %s @%0d: got %h want %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push_exp(input int unsigned at, input int unsigned what,
                          input logic [11:0] val, input string name);
    exp_t e;
    e.at = at; e.what = what; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  // One pixel per cycle; overlay/game bits are presented one cycle after their pixel.
  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic von,
                    input logic hs, input logic vs, input logic txt, input logic gm,
                    input logic key, input logic go);
    pixel_x = x; pixel_y = y; video_on = von; hsync = hs; vsync = vs;
    in_text = txt_prev; in_game = gm_prev;
    txt_prev = txt; gm_prev = gm;
    key_pressed = key; game_over = go;
    @(posedge clk_0); #1;
  endtask

  task automatic chk_px(input logic [9:0] y, input logic von, input logic hs, input logic vs,
                        input logic txt, input logic gm, input logic [11:0] exp_rgb,
                        input string name);
    push_exp(cyc + 2, 0, exp_rgb, name);
    push_exp(cyc + 2, 1, {11'd0, hs}, {name, "_hs"});
    push_exp(cyc + 2, 2, {11'd0, vs}, {name, "_vs"});
    px(10'd100, y, von, hs, vs, txt, gm, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic key, input logic go);
    px(10'd300, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, key, go);
  endtask

  task automatic tick();
    px(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_chk(input logic [1:0] st, input logic run, input string name);
    push_exp(cyc + 1, 3, {10'd0, st}, {name, "_state"});
    push_exp(cyc + 1, 4, {11'd0, run}, {name, "_run"});
    tick();
  endtask

  task automatic chk_reset(input string name);
    push_exp(cyc + 1, 0, 12'h000, {name, "_rgb"});
    push_exp(cyc + 1, 1, 12'h001, {name, "_hs"});
    push_exp(cyc + 1, 2, 12'h001, {name, "_vs"});
    push_exp(cyc + 1, 3, 12'h000, {name, "_state"});
    push_exp(cyc + 1, 4, 12'h000, {name, "_run"});
  endtask

  initial begin
    logic [11:0] exp200;

    // Reset
    rst = 1'b1;
    chk_reset("reset");
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    rst = 1'b0;

    // Title frame: text, sync delay, background, blanking
    tick_chk(2'd0, 1'b0, "title_tick");
    chk_px(10'd120, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFFF, "title_text");
    chk_px(10'd120, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "title_bg");
    chk_px(10'd120, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "title_blank");

    // Key mid-frame, second pulse before the tick
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    push_exp(cyc + 1, 3, 12'h000, "title_wait_state");
    idle(1'b1, 1'b0);
    tick_chk(2'd1, 1'b1, "title_to_play");
    idle(1'b0, 1'b0);
    tick_chk(2'd1, 1'b1, "play_stable");
    chk_px(10'd120, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "play_text_ignored");
    chk_px(10'd120, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, "play_game");

    // Simultaneous key and game_over in play
    push_exp(cyc + 1, 3, 12'h001, "play_wait_state");
    idle(1'b1, 1'b1);
    tick_chk(2'd2, 1'b0, "play_to_go");
    chk_px(10'd120, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h444, "go_dim");
    chk_px(10'd120, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, "go_text");
    chk_px(10'd120, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, "go_text_over_game");
    chk_px(10'd120, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, "go_bg");

    // Holdoff: keys in frames 1..60 ignored
    for (int f = 1; f <= 60; f++) begin
      idle(1'b1, 1'b0);
      if (f == 1 || f == 30 || f == 60) tick_chk(2'd2, 1'b0, $sformatf("holdoff_f%0d", f));
      else tick();
    end
    idle(1'b1, 1'b0);
    tick_chk(2'd0, 1'b0, "go_to_title");

    // Blink band over 60 title frames; rows above the band are always lit
    for (int j = 0; j < 60; j++) begin
`ifdef SCREEN_BLINK_EN
      exp200 = (j < 30) ? 12'hFFF : 12'h000;
`else
      exp200 = 12'hFFF;
`endif
      chk_px(10'd200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, exp200, $sformatf("blink_y200_f%0d", j));
      chk_px(10'd120, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, $sformatf("blink_y120_f%0d", j));
      tick();
    end

    // Reset while a title key is pending
    px(10'd100, 10'd120, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    chk_reset("midframe_rst");
    idle(1'b0, 1'b0);
    rst = 1'b0;
    tick_chk(2'd0, 1'b0, "no_trans_after_rst");

    // Drain the scoreboard
    repeat (5) idle(1'b0, 1'b0);
    if (sb.size() != 0) begin
      total += sb.size();
      bad += sb.size();
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
